// File: rtl/cdb_arbiter_pkg.sv
// Helpers local to the CDB arbiter: pointer sizing and saturating counter add.
package cdb_arbiter_pkg;

  localparam int          PERF_W   = 32;
  localparam logic [31:0] PERF_MAX = 32'hFFFF_FFFF;

  // Keeps a 1-entry configuration from collapsing the pointer to zero bits.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [PERF_W-1:0] sat_add(input logic [PERF_W-1:0] a,
                                                input logic [PERF_W-1:0] b);
    logic [PERF_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[PERF_W] ? PERF_MAX : sum[PERF_W-1:0];
  endfunction

endpackage

// File: rtl/cpu_params.sv
// Core-wide sizing constants shared by the backend blocks.
package cpu_params;

  localparam int XLEN        = 32;
  localparam int ROB_IDX_W   = 6;
  localparam int PRF_IDX_W   = 7;
  localparam int CDB_WIDTH   = 4;
  localparam int CDB_NUM_REQ = 6;

endpackage

// File: rtl/int_rs_types.sv
// Payload types exchanged between the integer functional units and the CDB.
package int_rs_types;

  import cpu_params::*;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_id;
    logic [4:0]           rd_arch;
    logic [PRF_IDX_W-1:0] rd_phy;
    logic [XLEN-1:0]      rd_value;
    logic [XLEN-1:0]      dbg_rs1;
    logic [XLEN-1:0]      dbg_rs2;
  } fu_cdb_reg_t;

endpackage

// File: rtl/cdb_rr_picker.sv
// Combinational rotating-priority selector: grants up to NUM_PORT valid
// requesters starting at rr_ptr and maps them, in scan order, onto ports.
module cdb_rr_picker #(
  parameter int NUM_REQ  = 6,
  parameter int NUM_PORT = 4,
  parameter int PTR_W    = 3
) (
  input  logic [NUM_REQ-1:0]                valid,
  input  logic [PTR_W-1:0]                  rr_ptr,
  output logic [NUM_REQ-1:0]                grant,
  output logic [NUM_PORT-1:0][PTR_W-1:0]    port_idx,
  output logic [NUM_PORT-1:0]               port_used,
  output logic [PTR_W-1:0]                  next_ptr
);

  localparam int PORT_W = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;

  always_comb begin
    int               cnt;
    int               idx;
    logic [PTR_W-1:0] idx_p;
    // NOTE: every output and temporary gets a default before the loop so no
    // path through the block leaves a value unassigned (no inferred latch).
    grant     = '0;
    port_idx  = '0;
    port_used = '0;
    next_ptr  = rr_ptr;
    cnt       = 0;
    idx       = 0;
    idx_p     = '0;
    for (int s = 0; s < NUM_REQ; s++) begin
      idx = int'(rr_ptr) + s;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_p = PTR_W'(idx);
      if (valid[idx_p] && (cnt < NUM_PORT)) begin
        grant[idx_p]                  = 1'b1;
        port_idx[PORT_W'(cnt)]        = idx_p;
        port_used[PORT_W'(cnt)]       = 1'b1;
        next_ptr = (idx == NUM_REQ - 1) ? '0 : PTR_W'(idx + 1);
        cnt = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: registers up to NUM_PORT granted FU results per
// cycle onto the CDB. Optional counters enabled by CDB_ARB_PERF_EN.
module cdb_arbiter
  import cpu_params::*;
  import int_rs_types::*;
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = CDB_NUM_REQ,
  parameter int NUM_PORT = CDB_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  fu_cdb_reg_t [NUM_REQ-1:0]         req_data,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [NUM_PORT-1:0]               cdb_valid,
  output fu_cdb_reg_t [NUM_PORT-1:0]        cdb_data
`ifdef CDB_ARB_PERF_EN
  ,
  output logic [PERF_W-1:0]                 perf_grants,
  output logic [PERF_W-1:0]                 perf_conflicts
`endif
);

  localparam int PTR_W = ptr_width(NUM_REQ);

  logic [PTR_W-1:0]             rr_ptr_q;
  logic [PTR_W-1:0]             next_ptr;
  logic [NUM_REQ-1:0]           grant;
  logic [NUM_PORT-1:0][PTR_W-1:0] port_idx;
  logic [NUM_PORT-1:0]          port_used;

  cdb_rr_picker #(
    .NUM_REQ  (NUM_REQ),
    .NUM_PORT (NUM_PORT),
    .PTR_W    (PTR_W)
  ) u_picker (
    .valid     (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .port_idx  (port_idx),
    .port_used (port_used),
    .next_ptr  (next_ptr)
  );

  // No handshake may complete while the bus is being squashed or held in reset.
  assign req_ready = (flush || !rst_n) ? '0 : grant;

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      cdb_valid <= '0;
    end else if (flush) begin
      cdb_valid <= '0;
    end else begin
      cdb_valid <= port_used;
      if (|port_used) rr_ptr_q <= next_ptr;
    end
  end

  // NOTE: the payload registers are reset because consumers expect a zero bus
  // after reset; idle ports simply hold their last payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_data <= '0;
    end else if (!flush) begin
      for (int j = 0; j < NUM_PORT; j++) begin
        if (port_used[j]) cdb_data[j] <= req_data[port_idx[j]];
      end
    end
  end

`ifdef CDB_ARB_PERF_EN
  logic [PERF_W-1:0] grant_cnt;
  logic [PERF_W-1:0] conflict_cnt;

  always_comb begin
    grant_cnt    = '0;
    conflict_cnt = '0;
    for (int j = 0; j < NUM_PORT; j++) grant_cnt = grant_cnt + PERF_W'(port_used[j]);
    for (int i = 0; i < NUM_REQ; i++)
      conflict_cnt = conflict_cnt + PERF_W'(req_valid[i] && !req_ready[i]);
  end

  // Flush cycles complete no handshakes, so they count neither grants nor conflicts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grants    <= '0;
      perf_conflicts <= '0;
    end else if (!flush) begin
      perf_grants    <= sat_add(perf_grants, grant_cnt);
      perf_conflicts <= sat_add(perf_conflicts, conflict_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (NUM_REQ=6, NUM_PORT=4).
module tb_cdb_arbiter;

  import cpu_params::*;
  import int_rs_types::*;

  localparam int NR = 6;
  localparam int NP = 4;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     flush = 1'b0;
  logic [NR-1:0]            req_valid = '0;
  fu_cdb_reg_t [NR-1:0]     req_data;
  logic [NR-1:0]            req_ready;
  logic [NP-1:0]            cdb_valid;
  fu_cdb_reg_t [NP-1:0]     cdb_data;
`ifdef CDB_ARB_PERF_EN
  logic [31:0]              perf_grants;
  logic [31:0]              perf_conflicts;
`endif

  int passed = 0;
  int total  = 0;

  cdb_arbiter #(.NUM_REQ(NR), .NUM_PORT(NP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cdb_valid (cdb_valid),
    .cdb_data  (cdb_data)
`ifdef CDB_ARB_PERF_EN
    ,
    .perf_grants    (perf_grants),
    .perf_conflicts (perf_conflicts)
`endif
  );

  always #5 clk = ~clk;

  function automatic fu_cdb_reg_t mk(input int i);
    fu_cdb_reg_t p;
    p.rob_id   = ROB_IDX_W'(i + 17);
    p.rd_arch  = 5'(i + 3);
    p.rd_phy   = PRF_IDX_W'(i * 9 + 40);
    p.rd_value = 32'hC0DE_0000 | 32'(i);
    p.dbg_rs1  = 32'h1111_0000 + 32'(i);
    p.dbg_rs2  = 32'h2222_0000 + 32'(i);
    return p;
  endfunction

  task automatic test_reset;
    req_valid = '1;
    #1;
    total++;
    if (req_ready !== 6'b000000) $display("FAIL reset_ready: got %b want %b", req_ready, 6'b000000);
    else passed++;
    total++;
    if (cdb_valid !== 4'b0000) $display("FAIL reset_cdb_valid: got %b want %b", cdb_valid, 4'b0000);
    else passed++;
    total++;
    if (cdb_data !== '0) $display("FAIL reset_cdb_data: got %h want 0", cdb_data);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (cdb_valid !== 4'b1111) $display("FAIL first_grant_valid: got %b want %b", cdb_valid, 4'b1111);
    else passed++;
    total++;
    if (cdb_data[0] !== mk(0)) $display("FAIL first_grant_port0: got %h want %h", cdb_data[0], mk(0));
    else passed++;
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (cdb_valid !== 4'b0000) $display("FAIL midreset_cdb_valid: got %b want %b", cdb_valid, 4'b0000);
    else passed++;
    total++;
    if (dut.rr_ptr_q !== 3'd0) $display("FAIL midreset_rr_ptr: got %0d want 0", dut.rr_ptr_q);
    else passed++;
    total++;
    if (req_ready !== 6'b000000) $display("FAIL midreset_ready: got %b want %b", req_ready, 6'b000000);
    else passed++;
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_light_load;
    @(negedge clk);
    req_valid = 6'b000101;
    #1;
    total++;
    if (req_ready !== 6'b000101) $display("FAIL light_ready: got %b want %b", req_ready, 6'b000101);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (cdb_valid !== 4'b0011) $display("FAIL light_cdb_valid: got %b want %b", cdb_valid, 4'b0011);
    else passed++;
    total++;
    if (cdb_data[0] !== mk(0)) $display("FAIL light_port0: got %h want %h", cdb_data[0], mk(0));
    else passed++;
    total++;
    if (cdb_data[1] !== mk(2)) $display("FAIL light_port1: got %h want %h", cdb_data[1], mk(2));
    else passed++;
    total++;
    if (dut.rr_ptr_q !== 3'd3) $display("FAIL light_rr_ptr: got %0d want 3", dut.rr_ptr_q);
    else passed++;
    @(negedge clk);
    req_valid = '0;
    @(posedge clk);
    #1;
    total++;
    if (cdb_valid !== 4'b0000) $display("FAIL light_one_cycle: got %b want %b", cdb_valid, 4'b0000);
    else passed++;
  endtask

  task automatic apply_reset;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_overload;
    logic [NR-1:0] exp_ready [3];
    int            exp_port  [3][NP];
    logic [2:0]    exp_ptr   [3];
    exp_ready[0] = 6'b001111; exp_ready[1] = 6'b110011; exp_ready[2] = 6'b111100;
    exp_port[0] = '{0, 1, 2, 3}; exp_port[1] = '{4, 5, 0, 1}; exp_port[2] = '{2, 3, 4, 5};
    exp_ptr[0] = 3'd4; exp_ptr[1] = 3'd2; exp_ptr[2] = 3'd0;
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_valid = '1;
      #1;
      total++;
      if (req_ready !== exp_ready[c])
        $display("FAIL overload_ready[c%0d]: got %b want %b", c, req_ready, exp_ready[c]);
      else passed++;
      @(posedge clk);
      #1;
      for (int j = 0; j < NP; j++) begin
        total++;
        if (cdb_data[j] !== mk(exp_port[c][j]))
          $display("FAIL overload_port%0d[c%0d]: got %h want %h", j, c, cdb_data[j], mk(exp_port[c][j]));
        else passed++;
      end
      total++;
      if (dut.rr_ptr_q !== exp_ptr[c])
        $display("FAIL overload_rr_ptr[c%0d]: got %0d want %0d", c, dut.rr_ptr_q, exp_ptr[c]);
      else passed++;
    end
  endtask

  task automatic test_flush;
    @(negedge clk);
    req_valid = 6'b000010;
    @(posedge clk);
    #1;
    total++;
    if (dut.rr_ptr_q !== 3'd2) $display("FAIL flush_setup_ptr: got %0d want 2", dut.rr_ptr_q);
    else passed++;
    @(negedge clk);
    req_valid = '1;
    flush = 1'b1;
    #1;
    total++;
    if (req_ready !== 6'b000000) $display("FAIL flush_ready: got %b want %b", req_ready, 6'b000000);
    else passed++;
    total++;
    if (cdb_valid !== 4'b0001) $display("FAIL flush_bus_visible: got %b want %b", cdb_valid, 4'b0001);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (cdb_valid !== 4'b0000) $display("FAIL flush_cdb_valid: got %b want %b", cdb_valid, 4'b0000);
    else passed++;
    total++;
    if (dut.rr_ptr_q !== 3'd2) $display("FAIL flush_rr_ptr: got %0d want 2", dut.rr_ptr_q);
    else passed++;
    @(negedge clk);
    flush = 1'b0;
    #1;
    total++;
    if (req_ready !== 6'b111100) $display("FAIL flush_resume_ready: got %b want %b", req_ready, 6'b111100);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (cdb_data[0] !== mk(2)) $display("FAIL flush_resume_port0: got %h want %h", cdb_data[0], mk(2));
    else passed++;
    total++;
    if (dut.rr_ptr_q !== 3'd0) $display("FAIL flush_resume_ptr: got %0d want 0", dut.rr_ptr_q);
    else passed++;
  endtask

  task automatic test_idle;
    @(negedge clk);
    req_valid = 6'b010000;
    @(posedge clk);
    #1;
    total++;
    if (dut.rr_ptr_q !== 3'd5) $display("FAIL idle_setup_ptr: got %0d want 5", dut.rr_ptr_q);
    else passed++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_valid = '0;
      @(posedge clk);
      #1;
      total++;
      if (cdb_valid !== 4'b0000) $display("FAIL idle_cdb_valid[c%0d]: got %b want %b", c, cdb_valid, 4'b0000);
      else passed++;
      total++;
      if (dut.rr_ptr_q !== 3'd5) $display("FAIL idle_rr_ptr[c%0d]: got %0d want 5", c, dut.rr_ptr_q);
      else passed++;
    end
  endtask

  task automatic test_wrap;
    @(negedge clk);
    req_valid = 6'b100011;
    #1;
    total++;
    if (req_ready !== 6'b100011) $display("FAIL wrap_ready: got %b want %b", req_ready, 6'b100011);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (cdb_valid !== 4'b0111) $display("FAIL wrap_cdb_valid: got %b want %b", cdb_valid, 4'b0111);
    else passed++;
    total++;
    if (cdb_data[0] !== mk(5)) $display("FAIL wrap_port0: got %h want %h", cdb_data[0], mk(5));
    else passed++;
    total++;
    if (cdb_data[1] !== mk(0)) $display("FAIL wrap_port1: got %h want %h", cdb_data[1], mk(0));
    else passed++;
    total++;
    if (cdb_data[2] !== mk(1)) $display("FAIL wrap_port2: got %h want %h", cdb_data[2], mk(1));
    else passed++;
    total++;
    if (dut.rr_ptr_q !== 3'd2) $display("FAIL wrap_rr_ptr: got %0d want 2", dut.rr_ptr_q);
    else passed++;
  endtask

  task automatic test_reset_flush;
    @(negedge clk);
    req_valid = '1;
    flush = 1'b1;
    rst_n = 1'b0;
    #1;
    total++;
    if (req_ready !== 6'b000000) $display("FAIL rstflush_ready: got %b want %b", req_ready, 6'b000000);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (dut.rr_ptr_q !== 3'd0) $display("FAIL rstflush_rr_ptr: got %0d want 0", dut.rr_ptr_q);
    else passed++;
    total++;
    if (cdb_data !== '0) $display("FAIL rstflush_cdb_data: got %h want 0", cdb_data);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    flush = 1'b0;
    req_valid = '0;
  endtask

`ifdef CDB_ARB_PERF_EN
  task automatic test_perf;
    @(negedge clk);
    req_valid = '1;
    @(posedge clk);
    #1;
    total++;
    if (perf_grants !== 32'd4) $display("FAIL perf_grants: got %0d want 4", perf_grants);
    else passed++;
    total++;
    if (perf_conflicts !== 32'd2) $display("FAIL perf_conflicts: got %0d want 2", perf_conflicts);
    else passed++;
    @(negedge clk);
    req_valid = '0;
    force dut.perf_grants = 32'hFFFF_FFFE;
    #1;
    release dut.perf_grants;
    @(negedge clk);
    req_valid = '1;
    @(posedge clk);
    #1;
    total++;
    if (perf_grants !== 32'hFFFF_FFFF) $display("FAIL perf_saturate: got %h want %h", perf_grants, 32'hFFFF_FFFF);
    else passed++;
    @(negedge clk);
    req_valid = '0;
  endtask
`endif

  initial begin
    for (int i = 0; i < NR; i++) req_data[i] = mk(i);
    test_reset();
    test_light_load();
    test_overload();
    test_flush();
    test_idle();
    test_wrap();
    test_reset_flush();
`ifdef CDB_ARB_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the CDB_WIDTH common data bus ports among all result-producing functional units: ALU, MDU, branch unit and LSU load return. Each cycle it grants up to CDB_WIDTH valid requesters in rotating-priority order and registers their results onto the CDB. The registered CDB feeds the PRF write ports, the RS wakeup logic, the RAT and the ROB. Sits between the FU output registers and the CDB consumers; a branch-mispredict flush squashes the bus.

## Interface
- NUM_REQ, default 6: number of FU requesters, minimum 1.
- NUM_PORT, default cpu_params::CDB_WIDTH (4): CDB ports driven, 1 ≤ NUM_PORT ≤ NUM_REQ.
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- flush, in, 1: squash all in-flight results (backend mispredict recovery).
- req_valid, in, NUM_REQ: requester i holds a result.
- req_data, in, NUM_REQ × fu_cdb_reg_t: result payload (rob_id, rd_arch, rd_phy, rd_value, debug operands).
- req_ready, out, NUM_REQ: requester i granted this cycle; handshake completes on valid && ready.
- cdb_valid, out, NUM_PORT: port k carries a result this cycle.
- cdb_data, out, NUM_PORT × fu_cdb_reg_t: port k payload.

## Operation
- State: rr_ptr (clog2(NUM_REQ) bits), cdb_valid / cdb_data output registers.
- Selection (combinational): scan requesters in order rr_ptr, rr_ptr+1, … modulo NUM_REQ. The first NUM_PORT with req_valid=1 are granted. The j-th granted requester in scan order maps to port j. Ports beyond the grant count are idle.
- req_ready[i] = granted[i] && !flush. It depends on req_valid. A requester must not make req_valid depend on req_ready, and must hold req_valid and req_data stable until granted.
- Register update on each edge, no flush: cdb_valid[j] ← port j used; cdb_data[j] ← payload of granted requester j. Unused ports load cdb_valid=0; cdb_data for unused ports is don't-care but must be held.
- rr_ptr update: when at least one grant occurs, set to (index of last granted requester + 1) mod NUM_REQ. With zero grants, unchanged.
  - Guarantees starvation freedom: a continuously valid requester is granted within ceil(NUM_REQ/NUM_PORT) cycles.
- Flush: req_ready all 0 in the flush cycle. cdb_valid all 0 on the next edge. rr_ptr unchanged. A result already on the bus in the flush cycle is still visible that cycle; consumers own squash of it.
- No requester can be granted on two ports in the same cycle. Wrap-around: with rr_ptr=NUM_REQ-1, the scan proceeds NUM_REQ-1, 0, 1, ….

## Timing
- Grant is same-cycle combinational from req_valid and rr_ptr.
- Latency: handshake at edge n puts the result on cdb_valid/cdb_data for cycle n+1. Results are visible exactly one cycle.
- Throughput: up to NUM_PORT results per cycle, sustained.
- Reset (asynchronous, rst_n=0): cdb_valid=0, cdb_data=0, rr_ptr=0, req_ready=0 while reset is held. A reset mid-transfer drops the registered results.
- Simultaneous flush and reset: reset dominates.

## Configuration
- CDB_ARB_PERF_EN defined: adds outputs perf_grants (32b) and perf_conflicts (32b), both reset to 0 and saturating at 2^32-1.
  - perf_grants increments by the grant count per cycle.
  - perf_conflicts increments by the number of requesters with req_valid=1 and req_ready=0, excluding flush cycles.
- CDB_ARB_PERF_EN undefined: the ports and counters are absent, and all other behaviour is identical.

## Structure
- Add CDB_NUM_REQ = 6 to cpu_params.
- Payload type stays int_rs_types::fu_cdb_reg_t; define no new typedef.
- One sub-module, cdb_rr_picker: purely combinational rotating multi-grant selector.
  - Inputs: valid vector, rr_ptr.
  - Outputs: grant vector, per-port requester index, per-port used flag, next_ptr.
- cdb_arbiter holds the registers, flush and perf logic.

## Test plan
- Reset: assert rst_n=0 mid-stream with cdb_valid=4'b1111 → cdb_valid=0 immediately, rr_ptr=0; first grant after release starts at requester 0.
- Light load: NUM_REQ=6, NUM_PORT=4, req_valid=6'b000101, rr_ptr=0 → req_ready=6'b000101; next cycle port0=req0 data, port1=req2 data, cdb_valid=4'b0011; rr_ptr=3.
- Overload and rotation: all 6 valid and held, rr_ptr=0 → cycle 0 grants 0,1,2,3, rr_ptr=4; cycle 1 grants 4,5,0,1 (wrap), rr_ptr=2; no requester waits more than 2 cycles.
- Flush: all valid with flush=1 → req_ready=0, next-cycle cdb_valid=0, rr_ptr unchanged; next cycle without flush grants resume from the same rr_ptr.
- Idle: req_valid=0 for 3 cycles with rr_ptr=5 → cdb_valid=0 and rr_ptr stays 5.
- Perf (CDB_ARB_PERF_EN): 6 valid requests for one cycle → perf_grants=4, perf_conflicts=2; preload perf_grants=32'hFFFF_FFFE and grant 4 → reads 32'hFFFF_FFFF.
